// File: rtl/arm_pkg.sv
// -----------------------------------------------------------------------------
// arm_pkg
// Definitions shared by the ALU, the main decoder and the conditional-execution
// logic:
//   - COND_* : encodings of the 4-bit Instr[31:28] condition field
//   - FLAG_* : bit positions of N, Z, C and V inside a {N,Z,C,V} flag vector
//   - nzcv_t : named view of a flag vector
//   - helper functions for field slicing and packing of flag vectors
// -----------------------------------------------------------------------------
package arm_pkg;

    // Condition field encodings
    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    // Encoding 4'hF has no mnemonic; it is treated as always-execute.
    localparam logic [3:0] COND_NV = 4'hF;

    // Flag bit positions in a {N,Z,C,V} vector
    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Named view of a flag vector; member order matches {N,Z,C,V}
    typedef struct packed {
        logic n;
        logic z;
        logic c;
        logic v;
    } nzcv_t;

    // N,Z field of a flag vector
    function automatic logic [1:0] nz_field(input logic [3:0] flags);
        return {flags[FLAG_N], flags[FLAG_Z]};
    endfunction

    // C,V field of a flag vector
    function automatic logic [1:0] cv_field(input logic [3:0] flags);
        return {flags[FLAG_C], flags[FLAG_V]};
    endfunction

    // Reassemble the two fields into a {N,Z,C,V} vector
    function automatic logic [3:0] pack_flags(input logic [1:0] nz,
                                              input logic [1:0] cv);
        return {nz, cv};
    endfunction

endpackage : arm_pkg

// File: rtl/cond_check.sv
// -----------------------------------------------------------------------------
// cond_check
// Purely combinational evaluation of an instruction condition field against
// the architectural flags. C is carry-out / no-borrow, so HI means unsigned
// greater-than after a compare.
// Ports:
//   cond     in  4  Instr[31:28] condition field
//   flags    in  4  {N,Z,C,V}
//   cond_ex  out 1  1 when the instruction is to execute
// Every one of the 16 encodings drives a known value; 4'hF executes always.
// -----------------------------------------------------------------------------
module cond_check
    import arm_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    nzcv_t f_s;
    logic  ge_s;

    assign f_s  = nzcv_t'(flags);
    // Signed greater-or-equal: N equals V
    assign ge_s = (f_s.n == f_s.v);

    // Condition decode
    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ: cond_ex = f_s.z;
            COND_NE: cond_ex = ~f_s.z;
            COND_CS: cond_ex = f_s.c;
            COND_CC: cond_ex = ~f_s.c;
            COND_MI: cond_ex = f_s.n;
            COND_PL: cond_ex = ~f_s.n;
            COND_VS: cond_ex = f_s.v;
            COND_VC: cond_ex = ~f_s.v;
            COND_HI: cond_ex = f_s.c & ~f_s.z;
            COND_LS: cond_ex = ~f_s.c | f_s.z;
            COND_GE: cond_ex = ge_s;
            COND_LT: cond_ex = ~ge_s;
            COND_GT: cond_ex = ~f_s.z & ge_s;
            COND_LE: cond_ex = f_s.z | ~ge_s;
            COND_AL: cond_ex = 1'b1;
            COND_NV: cond_ex = 1'b1;
            default: cond_ex = 1'b1;
        endcase
    end

endmodule : cond_check

// File: rtl/cond_logic.sv
// -----------------------------------------------------------------------------
// cond_logic
// Conditional-execution unit. Holds the architectural NZCV flags, evaluates
// each instruction's condition field against them and gates the decoder's
// write strobes.
// Parameters:
//   RESET_FLAGS  {N,Z,C,V} loaded by reset
// Ports:
//   clk       in  1  rising-edge clock
//   reset     in  1  asynchronous active-high reset of the flag register
//   Cond      in  4  Instr[31:28]
//   ALUFlags  in  4  {N,Z,C,V} produced by the ALU for this instruction
//   FlagW     in  2  [1] requests N,Z update; [0] requests C,V update
//   PCS       in  1  instruction writes the PC
//   RegW      in  1  instruction writes a register
//   MemW      in  1  instruction writes memory
//   NoWrite   in  1  compare-class op; never writes its destination register
//   PCSrc     out 1  PCS gated by CondEx
//   RegWrite  out 1  RegW gated by CondEx and NoWrite
//   MemWrite  out 1  MemW gated by CondEx
//   CondEx    out 1  condition passed against the registered flags
//   Flags     out 4  registered {N,Z,C,V}
// The gated outputs are combinational so the datapath sees them in the same
// cycle. Flags written by an instruction are first tested by the next one;
// there is deliberately no bypass from ALUFlags to the condition check.
// -----------------------------------------------------------------------------
module cond_logic
    import arm_pkg::*;
#(
    parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       MemW,
    input  logic       NoWrite,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       CondEx,
    output logic [3:0] Flags
);

    localparam logic [1:0] RESET_NZ = nz_field(RESET_FLAGS);
    localparam logic [1:0] RESET_CV = cv_field(RESET_FLAGS);

    logic [1:0] nz_r;
    logic [1:0] cv_r;
    logic [3:0] flags_s;
    logic       cond_ex_s;
    logic       nz_we_s;
    logic       cv_we_s;

    assign flags_s = pack_flags(nz_r, cv_r);

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags_s),
        .cond_ex (cond_ex_s)
    );

    // A failed condition blocks flag writes exactly like it blocks strobes
    assign nz_we_s = cond_ex_s & FlagW[1];
    assign cv_we_s = cond_ex_s & FlagW[0];

    // N,Z flag field register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            nz_r <= RESET_NZ;
        end else if (nz_we_s) begin
            nz_r <= nz_field(ALUFlags);
        end else begin
            nz_r <= nz_r;
        end
    end

    // C,V flag field register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cv_r <= RESET_CV;
        end else if (cv_we_s) begin
            cv_r <= cv_field(ALUFlags);
        end else begin
            cv_r <= cv_r;
        end
    end

    // Strobe gating
    always_comb begin
        PCSrc    = PCS & cond_ex_s;
        RegWrite = RegW & cond_ex_s & ~NoWrite;
        MemWrite = MemW & cond_ex_s;
        CondEx   = cond_ex_s;
        Flags    = flags_s;
    end

endmodule : cond_logic

// File: tb/tb_cond_logic.sv
// Directed bench for cond_logic: reset, flag latency, field independence,
// strobe gating, full condition sweep.
module tb_cond_logic;

    logic       clk;
    logic       reset;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic [1:0] FlagW;
    logic       PCS;
    logic       RegW;
    logic       MemW;
    logic       NoWrite;
    logic       PCSrc;
    logic       RegWrite;
    logic       MemWrite;
    logic       CondEx;
    logic [3:0] Flags;

    int checks;
    int failures;

    cond_logic #(.RESET_FLAGS(4'b0000)) dut (
        .clk      (clk),
        .reset    (reset),
        .Cond     (Cond),
        .ALUFlags (ALUFlags),
        .FlagW    (FlagW),
        .PCS      (PCS),
        .RegW     (RegW),
        .MemW     (MemW),
        .NoWrite  (NoWrite),
        .PCSrc    (PCSrc),
        .RegWrite (RegWrite),
        .MemWrite (MemWrite),
        .CondEx   (CondEx),
        .Flags    (Flags)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Independent reference of the condition table
    function automatic logic ref_cond(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    initial begin
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        Cond     = 4'hE;
        ALUFlags = 4'h0;
        FlagW    = 2'b00;
        PCS      = 1'b0;
        RegW     = 1'b0;
        MemW     = 1'b0;
        NoWrite  = 1'b0;
        #2;
        chk("reset_flags", Flags, 4'b0000);
        tick();
        reset = 1'b0;

        // 1. load 1111, then asynchronous reset mid-cycle
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111;
        tick();
        chk("load_1111", Flags, 4'b1111);
        FlagW = 2'b00;
        #3;
        reset = 1'b1;
        #1;
        chk("async_reset", Flags, 4'b0000);
        Cond = 4'h0; #1;
        chk("reset_eq", {3'b000, CondEx}, 4'b0001 & 4'b0000);
        Cond = 4'hE; PCS = 1'b1; RegW = 1'b1; MemW = 1'b1; #1;
        chk("reset_al", {3'b000, CondEx}, 4'b0001);
        chk("al_strobes", {1'b0, PCSrc, RegWrite, MemWrite}, 4'b0111);
        PCS = 1'b0; RegW = 1'b0; MemW = 1'b0;
        tick();
        chk("reset_held", Flags, 4'b0000);
        reset = 1'b0;

        // 2. SUBS 5-5 sets Z,C; visible next cycle
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0110;
        #1;
        chk("no_bypass", Flags, 4'b0000);
        tick();
        chk("subs_flags", Flags, 4'b0110);
        FlagW = 2'b00; Cond = 4'h0; #1;
        chk("eq_after_subs", {3'b000, CondEx}, 4'b0001);
        Cond = 4'h8; #1;
        chk("hi_after_subs", {3'b000, CondEx}, 4'b0000);

        // 3. failed NE blocks strobes and flag update
        Cond = 4'h1; FlagW = 2'b11; ALUFlags = 4'b1001;
        RegW = 1'b1; MemW = 1'b1; PCS = 1'b1; #1;
        chk("ne_fail_strobes", {CondEx, PCSrc, RegWrite, MemWrite}, 4'b0000);
        tick();
        chk("ne_fail_flags", Flags, 4'b0110);
        RegW = 1'b0; MemW = 1'b0; PCS = 1'b0;

        // 4. independent field updates
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b0000;
        tick();
        chk("clear_flags", Flags, 4'b0000);
        FlagW = 2'b10; ALUFlags = 4'b1011;
        tick();
        chk("nz_only", Flags, 4'b1000);
        FlagW = 2'b01; ALUFlags = 4'b0001;
        tick();
        chk("cv_only", Flags, 4'b1001);
        FlagW = 2'b00; ALUFlags = 4'b1111;
        tick();
        chk("no_flagw", Flags, 4'b1001);

        // 5. sweep every flag value against every condition
        for (int fv = 0; fv < 16; fv++) begin
            Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'(fv);
            tick();
            FlagW = 2'b00;
            chk("sweep_load", Flags, 4'(fv));
            for (int cv = 0; cv < 16; cv++) begin
                Cond = 4'(cv);
                #1;
                chk($sformatf("sweep_c%0h_f%0h", cv, fv), {3'b000, CondEx},
                    {3'b000, ref_cond(4'(cv), 4'(fv))});
            end
        end
        Cond = 4'hF; #1;
        chk("cond_1111", {3'b000, CondEx}, 4'b0001);

        // 6. CMP: no register write, memory strobe passes, flags still update
        Cond = 4'hE; RegW = 1'b1; NoWrite = 1'b1; MemW = 1'b1; PCS = 1'b0;
        FlagW = 2'b11; ALUFlags = 4'b0110; #1;
        chk("cmp_strobes", {CondEx, PCSrc, RegWrite, MemWrite}, 4'b1001);
        MemW = 1'b0; #1;
        chk("cmp_memw0", {CondEx, PCSrc, RegWrite, MemWrite}, 4'b1000);
        tick();
        chk("cmp_flags", Flags, 4'b0110);
        NoWrite = 1'b0; #1;
        chk("regw_pass", {CondEx, PCSrc, RegWrite, MemWrite}, 4'b1010);
        RegW = 1'b0;

        // 7. reset coincident with an update request wins
        Cond = 4'hE; FlagW = 2'b11; ALUFlags = 4'b1111;
        #7;
        reset = 1'b1;
        tick();
        chk("reset_wins", Flags, 4'b0000);
        reset = 1'b0;
        FlagW = 2'b00;
        tick();
        chk("after_reset", Flags, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_cond_logic
